// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB FSM driving the
// datapath control strobes, with a single shared memory port (req/ready)
// and a retired-instruction counter.
// Optional build macro: ILLEGAL_TRAP_EN adds a sticky TRAP state (code 7)
// and the illegal_instr output for invalid opcodes.
module multicycle_controller #(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic                 iord,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 reg_write,
  output logic                 mem_to_reg,
  output logic                 alu_src,
  output logic [1:0]           alu_op,
  output logic                 jal,
  output logic                 jalr,
  output logic                 lui,
  output logic [2:0]           state,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_instr,
`endif
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
`ifdef ILLEGAL_TRAP_EN
    , S_TRAP = 3'd7
`endif
  } state_e;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_e               state_q, state_d;
  logic [INSTRET_W-1:0] instret_q, instret_d;
  logic                 op_valid;

  // funct3 only feeds downstream ALU decode; sequencing ignores it
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  // Opcode legality check used in DECODE
  always_comb begin
    op_valid = 1'b0;
    case (opcode)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BR,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: op_valid = 1'b1;
      default:                           op_valid = 1'b0;
    endcase
  end

  // Next-state and control strobes; everything is forced low while rst_n
  // is asserted so an in-flight request drops asynchronously
  always_comb begin
    state_d       = state_q;
    instret_d     = instret_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src       = 1'b0;
    alu_op        = 2'b00;
    jal           = 1'b0;
    jalr          = 1'b0;
    lui           = 1'b0;
    retire        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src = 1'b1;
          if (op_valid) begin
            state_d = S_EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            state_d = S_TRAP;
`else
            state_d = S_FETCH;
`endif
          end
        end
        S_EXEC: begin
          case (opcode)
            OP_R: begin
              alu_op  = 2'b10;
              state_d = S_WB;
            end
            OP_I: begin
              alu_src = 1'b1;
              alu_op  = 2'b10;
              state_d = S_WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src = 1'b1;
              state_d = S_MEM;
            end
            OP_BR: begin
              alu_op        = 2'b01;
              pc_write_cond = 1'b1;
              retire        = 1'b1;
              state_d       = S_FETCH;
            end
            OP_JAL: begin
              jal       = 1'b1;
              reg_write = 1'b1;
              pc_write  = 1'b1;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            OP_JALR: begin
              jalr      = 1'b1;
              alu_src   = 1'b1;
              reg_write = 1'b1;
              pc_write  = 1'b1;
              retire    = 1'b1;
              state_d   = S_FETCH;
            end
            OP_LUI: begin
              lui     = 1'b1;
              state_d = S_WB;
            end
            OP_AUIPC: begin
              alu_src = 1'b1;
              state_d = S_WB;
            end
            default: state_d = S_FETCH;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write  = 1'b1;
          retire     = 1'b1;
          mem_to_reg = (opcode == OP_LOAD);
          lui        = (opcode == OP_LUI);
          state_d    = S_FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        S_TRAP: begin
          illegal_instr = 1'b1;
          state_d       = S_TRAP;
        end
`endif
        default: state_d = S_FETCH;
      endcase
      if (retire) begin
        instret_d = instret_q + INSTRET_W'(1);
      end
    end
  end

  // State and retired-instruction counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each instruction pushes its
// expected per-cycle state/strobe vector plus the mem_ready stimulus, and the
// runner pops one entry per cycle and compares at the falling edge.
module tb_multicycle_controller;

  localparam int unsigned W = 4;

  // ctrl vector bit positions
  localparam logic [14:0] REQ  = 15'h4000;
  localparam logic [14:0] WE   = 15'h2000;
  localparam logic [14:0] IORD = 15'h1000;
  localparam logic [14:0] IRW  = 15'h0800;
  localparam logic [14:0] PCW  = 15'h0400;
  localparam logic [14:0] PCWC = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] M2R  = 15'h0080;
  localparam logic [14:0] SRC  = 15'h0040;
  localparam logic [14:0] OP10 = 15'h0020;
  localparam logic [14:0] OP01 = 15'h0010;
  localparam logic [14:0] JAL  = 15'h0008;
  localparam logic [14:0] JALR = 15'h0004;
  localparam logic [14:0] LUI  = 15'h0002;
  localparam logic [14:0] RET  = 15'h0001;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_BAD   = 7'b1111111;

  logic         clk, rst_n;
  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic         mem_ready;
  logic         mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic         reg_write, mem_to_reg, alu_src, jal, jalr, lui, retire;
  logic [1:0]   alu_op;
  logic [2:0]   state;
  logic [W-1:0] instret;
`ifdef ILLEGAL_TRAP_EN
  logic         illegal_instr;
`endif

  multicycle_controller #(.INSTRET_W(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .iord         (iord),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .alu_src      (alu_src),
    .alu_op       (alu_op),
    .jal          (jal),
    .jalr         (jalr),
    .lui          (lui),
    .state        (state),
`ifdef ILLEGAL_TRAP_EN
    .illegal_instr(illegal_instr),
`endif
    .retire       (retire),
    .instret      (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rdy;
    logic [6:0]  op;
    logic [2:0]  st;
    logic [14:0] ctrl;
  } ent_t;

  ent_t         sb[$];
  logic [6:0]   cur_op;
  logic [W-1:0] exp_instret;
  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] ctrl_now();
    return {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, reg_write,
            mem_to_reg, alu_src, alu_op, jal, jalr, lui, retire};
  endfunction

  task automatic push(input logic rdy, input logic [2:0] st, input logic [14:0] ctrl);
    ent_t e;
    e.rdy = rdy; e.op = cur_op; e.st = st; e.ctrl = ctrl;
    sb.push_back(e);
  endtask

  // mem_ready must be ignored outside FETCH/MEM, so drive noise there
  function automatic logic noise();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push_fetch(input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) push(1'b0, 3'd0, REQ);
    push(1'b1, 3'd0, REQ | IRW | PCW);
    push(noise(), 3'd1, SRC);
  endtask

  task automatic push_instr(input logic [6:0] op, input int unsigned fw, input int unsigned mw);
    cur_op = op;
    push_fetch(fw);
    case (op)
      OP_R:     begin push(noise(), 3'd2, OP10);       push(noise(), 3'd4, RW | RET); end
      OP_I:     begin push(noise(), 3'd2, SRC | OP10); push(noise(), 3'd4, RW | RET); end
      OP_LUI:   begin push(noise(), 3'd2, LUI);        push(noise(), 3'd4, RW | RET | LUI); end
      OP_AUIPC: begin push(noise(), 3'd2, SRC);        push(noise(), 3'd4, RW | RET); end
      OP_LOAD: begin
        push(noise(), 3'd2, SRC);
        for (int unsigned i = 0; i < mw; i++) push(1'b0, 3'd3, REQ | IORD);
        push(1'b1, 3'd3, REQ | IORD);
        push(noise(), 3'd4, RW | RET | M2R);
      end
      OP_STORE: begin
        push(noise(), 3'd2, SRC);
        for (int unsigned i = 0; i < mw; i++) push(1'b0, 3'd3, REQ | IORD | WE);
        push(1'b1, 3'd3, REQ | IORD | WE | RET);
      end
      OP_BR:   push(noise(), 3'd2, OP01 | PCWC | RET);
      OP_JAL:  push(noise(), 3'd2, JAL | RW | PCW | RET);
      OP_JALR: push(noise(), 3'd2, JALR | SRC | RW | PCW | RET);
      default: ;
    endcase
  endtask

  // Called at posedge+1; leaves time at posedge+1
  task automatic run_queue();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ready = e.rdy;
      opcode    = e.op;
      funct3    = 3'($urandom_range(0, 7));
      @(negedge clk);
      check_eq("state", 32'(state), 32'(e.st));
      check_eq("ctrl", 32'(ctrl_now()), 32'(e.ctrl));
      check_eq("instret", 32'(instret), 32'(exp_instret));
`ifdef ILLEGAL_TRAP_EN
      check_eq("illegal_instr", 32'(illegal_instr), 32'(e.st == 3'd7));
`endif
      @(posedge clk);
      if (e.ctrl[0]) exp_instret = exp_instret + 1'b1;
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b0; opcode = OP_R; funct3 = 3'd0;
    cur_op = OP_R; exp_instret = '0;
    #1;
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_ctrl", 32'(ctrl_now()), 32'd0);
    check_eq("rst_instret", 32'(instret), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_instr(OP_R, 0, 0);
    push_instr(OP_LOAD, 0, 2);
    push_instr(OP_STORE, 1, 1);
    push_instr(OP_BR, 0, 0);
    push_instr(OP_JAL, 0, 0);
    push_instr(OP_JALR, 2, 0);
    push_instr(OP_I, 0, 0);
    push_instr(OP_LUI, 0, 0);
    push_instr(OP_AUIPC, 0, 0);
    run_queue();

    // 16 branch retires wrap the 4-bit counter through 15 -> 0
    for (int unsigned i = 0; i < 16; i++) push_instr(OP_BR, 0, 0);
    run_queue();
    check_eq("wrap_instret", 32'(instret), 32'(4'd9));

    // Load parked in MEM, then asynchronous reset mid-cycle
    cur_op = OP_LOAD;
    push_fetch(0);
    push(noise(), 3'd2, SRC);
    push(1'b0, 3'd3, REQ | IORD);
    run_queue();
    mem_ready = 1'b0;
    check_eq("mem_state", 32'(state), 32'd3);
    check_eq("mem_req_pre", 32'(mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_mid_state", 32'(state), 32'd0);
    check_eq("rst_mid_instret", 32'(instret), 32'd0);
    check_eq("rst_mid_ctrl", 32'(ctrl_now()), 32'd0);
    exp_instret = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    push_instr(OP_R, 0, 0);
    // Invalid opcode
    cur_op = OP_BAD;
    push_fetch(0);
`ifdef ILLEGAL_TRAP_EN
    for (int unsigned i = 0; i < 6; i++) push(noise(), 3'd7, 15'h0);
`else
    push(1'b0, 3'd0, REQ);
    cur_op = OP_R;
    push(1'b1, 3'd0, REQ | IRW | PCW);
`endif
    run_queue();
    check_eq("final_instret", 32'(instret), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I core datapath. Replaces single-cycle decode with a five-state FSM that issues per-state control strobes.
- Memory is a single shared port (instruction and data) with a req/ready handshake.
- Decodes the same opcode set as the single-cycle control unit: R, I, Load, Store, Branch, JAL, JALR, LUI, AUIPC.
- Maintains a retired-instruction counter.

Parameters:
- INSTRET_W, 32, width of the retired-instruction counter (wraps modulo 2^INSTRET_W).

Ports:
- clk  input  1  single system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- opcode  input  7  instr[6:0] from the instruction register
- funct3  input  3  instr[14:12] from the instruction register
- mem_ready  input  1  memory completes the current request this cycle
- mem_req  output  1  memory request valid
- mem_we  output  1  write request, valid only with mem_req
- iord  output  1  0 = address from PC, 1 = address from ALU result
- ir_write  output  1  load the instruction register
- pc_write  output  1  unconditional PC update
- pc_write_cond  output  1  PC update if the branch comparison is true
- reg_write  output  1  register file write enable
- mem_to_reg  output  1  write-back source is memory data
- alu_src  output  1  ALU operand B is the immediate
- alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded
- jal, jalr, lui  output  1 each  PC/write-back mux selects
- state  output  3  current state encoding, for debug
- retire  output  1  one-cycle pulse when an instruction completes
- instret  output  INSTRET_W  count of retired instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH(0), instret=0.
  - All strobes, retire, alu_op and mux selects are 0.
  - An in-flight memory request is abandoned. mem_req deasserts immediately and asynchronously.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4. Codes 5–7 are unreachable and recover to FETCH.
- Outputs are combinational from state and opcode. Strobes qualified by mem_ready are Mealy.
- FETCH:
  - mem_req=1, iord=0, mem_we=0.
  - Stay while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC+4), next state DECODE.
- DECODE:
  - One cycle.
  - alu_src=1, alu_op=00 (branch target precompute).
  - Next state EXEC for a valid opcode. Invalid opcode behaviour is given under Optional Feature.
- EXEC:
  - R-type: alu_src=0, alu_op=10, next WB.
  - I-type: alu_src=1, alu_op=10, next WB.
  - Load/Store: alu_src=1, alu_op=00, next MEM.
  - Branch: alu_op=01, branch-compare, pc_write_cond=1, retire=1, next FETCH.
  - JAL: jal=1, reg_write=1, pc_write=1, retire=1, next FETCH.
  - JALR: jalr=1, alu_src=1, reg_write=1, pc_write=1, retire=1, next FETCH.
  - LUI: lui=1, next WB.
  - AUIPC: alu_src=1, alu_op=00, next WB.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for Store only.
  - Hold all outputs stable until mem_ready.
  - Load on ready: next WB.
  - Store on ready: retire=1, next FETCH.
- WB:
  - reg_write=1, retire=1, next FETCH.
  - mem_to_reg=1 for Load only. lui=1 for LUI.
- Handshake:
  - mem_req stays high until mem_ready is sampled high.
  - mem_ready while mem_req=0 is ignored.
  - mem_ready high in the same cycle mem_req rises completes the request in zero wait states.
- Latency with zero wait states:
  - Branch/JAL/JALR: 3 cycles.
  - R/I/LUI/AUIPC/Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- instret: increments on every retire. At all-ones it wraps to 0. funct3 is passed only for alu_op=10 decoding downstream and does not affect sequencing.

Optional Feature:
- Macro: ILLEGAL_TRAP_EN.
- Defined:
  - An invalid opcode in DECODE enters TRAP (state 7), which is sticky.
  - Output illegal_instr=1 in TRAP.
  - All strobes 0 in TRAP; no retire.
  - Only rst_n exits TRAP.
- Undefined:
  - illegal_instr port absent.
  - An invalid opcode in DECODE goes to FETCH with no writes and no retire (NOP, PC already advanced).
  - State 7 is treated as unreachable.

Test Plan:
- Reset mid-MEM:
  - Stimulus: Load with mem_ready held 0, rst_n=0 while in MEM.
  - Required: mem_req=0 same cycle, state=0, instret=0.
- R-type (0110011), zero-wait memory:
  - Required state sequence: 0→1→2→4→0.
  - In EXEC: alu_op=10, alu_src=0.
  - In WB: reg_write=1, retire=1.
  - instret increments by 1 over 4 cycles.
- Load (0000011), 2 wait states in MEM:
  - Required: mem_req held 3 cycles with iord=1, mem_we=0.
  - WB has mem_to_reg=1.
  - Total 7 cycles.
- Store (0100011), then Branch (1100011):
  - Store: mem_we=1 in MEM, retire in MEM, never reg_write.
  - Branch: pc_write_cond=1, alu_op=01 in EXEC, retire after 3 cycles.
- JAL (1101111) and JALR (1100111):
  - JAL: jal=1 with reg_write=1 and pc_write=1 in EXEC.
  - JALR: jalr=1 with alu_src=1 in EXEC.
  - Each returns to FETCH next cycle.
- Invalid opcode 1111111, and instret wrap with INSTRET_W=4:
  - With ILLEGAL_TRAP_EN: state=7, illegal_instr=1, held indefinitely.
  - Without ILLEGAL_TRAP_EN: DECODE→FETCH, no reg_write.
  - Wrap: 16 retires take instret 15→0.
